// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types for the 6502C/DMA bus arbiter: owner states, counter and index widths.
// The optional DMA_ARB_ROUND_ROBIN_EN macro selects the arbitration policy in arb_pick.
package dma_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        CPU_OWN,
        HALT_REQ,
        DMA_OWN,
        RELEASE
    } arb_state_t;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned MAX_REQ = 4;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (oh[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_arb_pick.sv
// Requester selection: one-hot winner from the request vector and last-winner pointer.
// DMA_ARB_ROUND_ROBIN_EN defined: round-robin from last winner + 1; otherwise lowest index wins.
module arb_pick
    import dma_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_win,
    output logic [NUM_REQ-1:0] win
);

`ifdef DMA_ARB_ROUND_ROBIN_EN
    always_comb begin
        int unsigned tgt;
        logic        found;
        win   = '0;
        found = 1'b0;
        tgt   = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            tgt = 32'(last_win) + i;
            if (tgt >= NUM_REQ) tgt = tgt - NUM_REQ;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!found && req[k] && k == tgt) begin
                    win[k] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last_win;

    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k]) begin
                win[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the external memory bus between the 6502C core and NUM_REQ DMA requesters,
// halting the CPU via RDY on a read cycle. Policy macro: DMA_ARB_ROUND_ROBIN_EN.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned MAX_BURST     = 8,
    parameter int unsigned HALT_WAIT_MAX = 3
) (
    input  logic                  phi2,
    input  logic                  RES_L,
    input  logic [15:0]           cpu_AB,
    input  logic                  cpu_RW,
    input  logic [NUM_REQ-1:0]    dma_req,
    input  logic [16*NUM_REQ-1:0] dma_AB,
    input  logic [NUM_REQ-1:0]    dma_RW,
    output logic                  RDY,
    output logic [NUM_REQ-1:0]    dma_gnt,
    output logic [15:0]           mem_AB,
    output logic                  mem_RW,
    output logic                  halt_err
);

    arb_state_t         state;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   last_idx;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   burst_cnt;
    logic [CNT_W-1:0]   wait_nxt;
    logic [CNT_W-1:0]   burst_nxt;
    logic               rdy_q;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               win_req;

    arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req      (dma_req),
        .last_win (last_idx),
        .win      (pick_oh)
    );

    assign pick_idx = onehot_to_idx(MAX_REQ'(pick_oh));
    assign win_req  = |(dma_req & win_oh);
    assign wait_nxt  = (wait_cnt  == '1) ? wait_cnt  : wait_cnt  + 1'b1;
    assign burst_nxt = (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;

    assign RDY     = rdy_q;
    assign dma_gnt = gnt_q;

    always_comb begin
        mem_AB = cpu_AB;
        mem_RW = cpu_RW;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_q[k]) begin
                mem_AB = dma_AB[16*k +: 16];
                mem_RW = dma_RW[k];
            end
        end
    end

    always_ff @(posedge phi2 or negedge RES_L) begin
        if (!RES_L) begin
            state     <= CPU_OWN;
            win_oh    <= '0;
            gnt_q     <= '0;
            last_idx  <= IDX_W'(NUM_REQ - 1);
            wait_cnt  <= '0;
            burst_cnt <= '0;
            rdy_q     <= 1'b1;
            halt_err  <= 1'b0;
        end else begin
            case (state)
                CPU_OWN: begin
                    if (|dma_req) begin
                        state    <= HALT_REQ;
                        win_oh   <= pick_oh;
                        last_idx <= pick_idx;
                        wait_cnt <= '0;
                        rdy_q    <= 1'b0;
                    end
                end
                HALT_REQ: begin
                    if (!win_req) begin
                        state <= RELEASE;
                        rdy_q <= 1'b1;
                    end else if (cpu_RW) begin
                        state     <= DMA_OWN;
                        burst_cnt <= '0;
                        gnt_q     <= win_oh;
                    end else begin
                        // Error only once HALT_WAIT_MAX write cycles have already been waited out.
                        wait_cnt <= wait_nxt;
                        if (wait_cnt >= CNT_W'(HALT_WAIT_MAX)) halt_err <= 1'b1;
                    end
                end
                DMA_OWN: begin
                    burst_cnt <= burst_nxt;
                    if (!win_req || burst_nxt >= CNT_W'(MAX_BURST)) begin
                        state <= RELEASE;
                        rdy_q <= 1'b1;
                        gnt_q <= '0;
                    end
                end
                RELEASE: state <= CPU_OWN;
                default: state <= CPU_OWN;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: transaction-level model plus directed literal checks.
// Expected arbitration order follows DMA_ARB_ROUND_ROBIN_EN when defined.
module tb_dma_bus_arbiter;

    localparam int NREQ  = 2;
    localparam int BURST = 8;
    localparam int HWAIT = 3;

    logic        phi2 = 1'b0;
    logic        RES_L;
    logic [15:0] cpu_AB;
    logic        cpu_RW;
    logic [1:0]  dma_req;
    logic [31:0] dma_AB;
    logic [1:0]  dma_RW;
    logic        RDY;
    logic [1:0]  dma_gnt;
    logic [15:0] mem_AB;
    logic        mem_RW;
    logic        halt_err;

    int n_checks = 0;
    int n_errors = 0;

    dma_bus_arbiter #(
        .NUM_REQ       (NREQ),
        .MAX_BURST     (BURST),
        .HALT_WAIT_MAX (HWAIT)
    ) dut (
        .phi2     (phi2),
        .RES_L    (RES_L),
        .cpu_AB   (cpu_AB),
        .cpu_RW   (cpu_RW),
        .dma_req  (dma_req),
        .dma_AB   (dma_AB),
        .dma_RW   (dma_RW),
        .RDY      (RDY),
        .dma_gnt  (dma_gnt),
        .mem_AB   (mem_AB),
        .mem_RW   (mem_RW),
        .halt_err (halt_err)
    );

    always #5 phi2 = ~phi2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who is being halted for, who holds the bus, cooldown after a tenure.
    int m_halt_for = -1;
    int m_grant    = -1;
    bit m_cool     = 1'b0;
    int m_waits    = 0;
    int m_beats    = 0;
    bit m_err      = 1'b0;
    int m_rr_next  = 0;

    function automatic int choose(input logic [1:0] req);
        int k;
`ifdef DMA_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < NREQ; i++) begin
            k = (m_rr_next + i) % NREQ;
            if (req[k]) begin
                m_rr_next = (k + 1) % NREQ;
                return k;
            end
        end
`else
        for (k = 0; k < NREQ; k++) if (req[k]) return k;
`endif
        return -1;
    endfunction

    always @(posedge phi2 or negedge RES_L) begin
        if (!RES_L) begin
            m_halt_for = -1; m_grant = -1; m_cool = 0;
            m_waits = 0; m_beats = 0; m_err = 0; m_rr_next = 0;
        end else if (m_cool) begin
            m_cool = 0;
        end else if (m_grant >= 0) begin
            m_beats++;
            if (!dma_req[m_grant] || m_beats == BURST) begin
                m_grant = -1;
                m_cool  = 1;
            end
        end else if (m_halt_for >= 0) begin
            if (!dma_req[m_halt_for]) begin
                m_halt_for = -1;
                m_cool     = 1;
            end else if (cpu_RW) begin
                m_grant    = m_halt_for;
                m_halt_for = -1;
                m_beats    = 0;
            end else begin
                if (m_waits >= HWAIT) m_err = 1;
                m_waits++;
            end
        end else if (dma_req != 2'b00) begin
            m_halt_for = choose(dma_req);
            m_waits    = 0;
        end
    end

    always @(negedge phi2) begin
        logic [1:0]  e_gnt;
        logic [15:0] e_ab;
        logic        e_rw;
        e_gnt = (m_grant >= 0) ? 2'(1 << m_grant) : 2'b00;
        e_ab  = (m_grant == 1) ? dma_AB[31:16] : (m_grant == 0) ? dma_AB[15:0] : cpu_AB;
        e_rw  = (m_grant >= 0) ? dma_RW[m_grant] : cpu_RW;
        chk("model_RDY", 32'(RDY), 32'(!(m_halt_for >= 0 || m_grant >= 0)));
        chk("model_gnt", 32'(dma_gnt), 32'(e_gnt));
        chk("model_mem_AB", 32'(mem_AB), 32'(e_ab));
        chk("model_mem_RW", 32'(mem_RW), 32'(e_rw));
        chk("model_halt_err", 32'(halt_err), 32'(m_err));
    end

    // Record each grant as it rises.
    logic [1:0] winners [64];
    int         g_cnt  = 0;
    logic [1:0] g_prev = 2'b00;
    always @(negedge phi2) begin
        if (dma_gnt != 2'b00 && g_prev == 2'b00 && g_cnt < 64) begin
            winners[g_cnt] = dma_gnt;
            g_cnt++;
        end
        g_prev = dma_gnt;
    end

    task automatic tick();
        @(posedge phi2);
        #1;
    endtask

    initial begin
        int         g0;
        logic [1:0] exp_seq [3];

        RES_L = 1'b0; cpu_AB = 16'h1234; cpu_RW = 1'b1;
        dma_req = 2'b00; dma_AB = {16'hE000, 16'hD400}; dma_RW = 2'b10;
        repeat (3) tick();
        chk("reset_RDY", 32'(RDY), 32'd1);
        chk("reset_gnt", 32'(dma_gnt), 32'd0);
        chk("reset_mem_AB", 32'(mem_AB), 32'h1234);
        RES_L = 1'b1;
        repeat (2) tick();

        // Single request while CPU reads: one halt cycle then grant.
        dma_req = 2'b01;
        tick();
        chk("single_halt_RDY", 32'(RDY), 32'd0);
        chk("single_halt_gnt", 32'(dma_gnt), 32'd0);
        tick();
        chk("single_gnt", 32'(dma_gnt), 32'b01);
        chk("single_mem_AB", 32'(mem_AB), 32'hD400);
        chk("single_mem_RW", 32'(mem_RW), 32'd0);
        dma_req = 2'b00;
        tick();
        chk("single_release_RDY", 32'(RDY), 32'd1);
        tick();

        // Three CPU writes during the halt: no error.
        cpu_RW = 1'b0; cpu_AB = 16'h01FD; dma_req = 2'b01;
        tick();
        repeat (3) tick();
        chk("wr3_still_halting", 32'(RDY), 32'd0);
        chk("wr3_no_gnt", 32'(dma_gnt), 32'd0);
        cpu_RW = 1'b1;
        tick();
        chk("wr3_gnt", 32'(dma_gnt), 32'b01);
        chk("wr3_halt_err", 32'(halt_err), 32'd0);
        dma_req = 2'b00;
        repeat (2) tick();

        // Four CPU writes: error flagged, grant still follows.
        cpu_RW = 1'b0; dma_req = 2'b01;
        tick();
        repeat (4) tick();
        chk("wr4_halt_err", 32'(halt_err), 32'd1);
        cpu_RW = 1'b1;
        tick();
        chk("wr4_gnt", 32'(dma_gnt), 32'b01);
        dma_req = 2'b00;
        repeat (2) tick();

        // Held request: 8-cycle burst, one release cycle, re-grant after 3 edges.
        dma_req = 2'b01;
        tick();
        for (int i = 0; i < BURST; i++) begin
            tick();
            chk("burst_gnt", 32'(dma_gnt), 32'b01);
        end
        tick();
        chk("burst_release_gnt", 32'(dma_gnt), 32'd0);
        chk("burst_release_RDY", 32'(RDY), 32'd1);
        tick();
        chk("burst_cpu_RDY", 32'(RDY), 32'd1);
        tick();
        chk("burst_halt_RDY", 32'(RDY), 32'd0);
        tick();
        chk("burst_regrant", 32'(dma_gnt), 32'b01);
        dma_req = 2'b00;
        repeat (2) tick();

        // Both requesting: order of the next three grants.
        g0 = g_cnt;
        dma_req = 2'b11;
        repeat (36) tick();
        dma_req = 2'b00;
        repeat (3) tick();
`ifdef DMA_ARB_ROUND_ROBIN_EN
        exp_seq = '{2'b10, 2'b01, 2'b10};
`else
        exp_seq = '{2'b01, 2'b01, 2'b01};
`endif
        for (int i = 0; i < 3; i++) chk("dual_winner", 32'(winners[g0 + i]), 32'(exp_seq[i]));

        // Request abandoned during the halt: release without any grant.
        g0 = g_cnt;
        cpu_RW = 1'b0; dma_req = 2'b01;
        tick();
        dma_req = 2'b00;
        tick();
        chk("abandon_RDY", 32'(RDY), 32'd1);
        chk("abandon_gnt", 32'(dma_gnt), 32'd0);
        cpu_RW = 1'b1;
        repeat (2) tick();
        @(negedge phi2); #1;
        chk("abandon_no_grant_pulse", 32'(g_cnt - g0), 32'd0);

        // Reset asserted mid-burst takes effect without a clock edge.
        dma_req = 2'b10; cpu_AB = 16'h4321;
        repeat (3) tick();
        chk("midburst_gnt", 32'(dma_gnt), 32'b10);
        chk("midburst_mem_AB", 32'(mem_AB), 32'hE000);
        #1 RES_L = 1'b0;
        #1;
        chk("async_rst_RDY", 32'(RDY), 32'd1);
        chk("async_rst_gnt", 32'(dma_gnt), 32'd0);
        chk("async_rst_mem_AB", 32'(mem_AB), 32'h4321);
        chk("async_rst_halt_err", 32'(halt_err), 32'd0);
        dma_req = 2'b00;
        repeat (2) tick();
        RES_L = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
